// File: rtl/lif_chain.sv
// Feed-forward chain of leaky integrate-and-fire neurons. Neuron 0 integrates isyn;
// each later neuron receives WEIGHT whenever its predecessor fired on the previous step.
module lif_chain #(
  parameter int          N_NEURONS  = 3,
  parameter int          W          = 8,
  parameter int          LEAK_SHIFT = 2,
  parameter int          REFRAC     = 2,
  parameter logic [W-1:0] WEIGHT    = W'(255),
  localparam int         SEL_W      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step,
  input  logic [W-1:0]         isyn,
  input  logic [W-1:0]         thresh,
  input  logic                 cnt_clr,
  input  logic [SEL_W-1:0]     mon_sel,
  output logic [N_NEURONS-1:0] spike,
  output logic [W-1:0]         mon_v,
  output logic [15:0]          spike_cnt
);

  localparam int             RW       = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [RW-1:0]  REFRAC_V = RW'(REFRAC);

  logic [W-1:0]         v_q [N_NEURONS];
  logic [W-1:0]         v_d [N_NEURONS];
  logic [RW-1:0]        r_q [N_NEURONS];
  logic [RW-1:0]        r_d [N_NEURONS];
  logic [N_NEURONS-1:0] spike_q, spike_d;
  logic [15:0]          cnt_q, cnt_d;

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
    logic [W-1:0]  in_i;
    logic [W-1:0]  leaked;
    logic [W:0]    sum_raw;
    logic [W-1:0]  sum_sat;
    logic          fire;
    logic [W-1:0]  v_nxt;
    logic [RW-1:0] r_nxt;
    logic          spk_nxt;

    // Stage inputs come from the registered spike of the previous stage.
    if (i == 0) begin : g_head
      assign in_i = isyn;
    end else begin : g_tail
      assign in_i = spike_q[i-1] ? WEIGHT : '0;
    end

    assign leaked  = v_q[i] - (v_q[i] >> LEAK_SHIFT);
    assign sum_raw = {1'b0, leaked} + {1'b0, in_i};
    assign sum_sat = sum_raw[W] ? {W{1'b1}} : sum_raw[W-1:0];
    assign fire    = (sum_sat >= thresh);

    always_comb begin
      v_nxt   = v_q[i];
      r_nxt   = r_q[i];
      spk_nxt = 1'b0;
      if (step) begin
        if (r_q[i] != '0) begin
          r_nxt = r_q[i] - RW'(1);
          v_nxt = '0;
        end else if (fire) begin
          spk_nxt = 1'b1;
          v_nxt   = '0;
          r_nxt   = REFRAC_V;
        end else begin
          v_nxt = sum_sat;
        end
      end
    end

    assign v_d[i]     = v_nxt;
    assign r_d[i]     = r_nxt;
    assign spike_d[i] = spk_nxt;
  end

  // Count tracks the spike being registered this edge; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (spike_d[N_NEURONS-1]) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= '0;
        r_q[i] <= '0;
      end
      spike_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= v_d[i];
        r_q[i] <= r_d[i];
      end
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    mon_v = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (int'(mon_sel) == i) begin
        mon_v = v_q[i];
      end
    end
  end

  assign spike     = spike_q;
  assign spike_cnt = cnt_q;

endmodule

// File: doc/lif_chain.md
LIF_CHAIN -- requirements
Module: lif_chain

Interface
REQ-001 Parameters SHALL be:
- N_NEURONS, default 3: neurons in the feed-forward chain, at least 1.
- W, default 8: membrane, input and threshold width, at least 4.
- LEAK_SHIFT, default 2: leak is V >> LEAK_SHIFT, range 1..W-1.
- REFRAC, default 2: refractory length in steps, 0 allowed.
- WEIGHT, default 255 (W bits): synaptic input a spike delivers to the next neuron.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- step, in, 1: advance all neurons one time step this cycle.
- isyn, in, W: synaptic current into neuron 0.
- thresh, in, W: firing threshold shared by all neurons, sampled every step.
- cnt_clr, in, 1: synchronous clear of spike_cnt.
- mon_sel, in, clog2(N_NEURONS) (min 1): neuron whose membrane drives mon_v.
- spike, out, N_NEURONS: registered spike pulses, bit i for neuron i.
- mon_v, out, W: membrane of the selected neuron.
- spike_cnt, out, 16: count of spikes from neuron N_NEURONS-1.

Function
REQ-003 Each neuron i SHALL hold registered state V_i (W bits, unsigned), refractory counter R_i (0..REFRAC) and spike[i].
REQ-004 Input I_0 SHALL be isyn; I_i for i>0 SHALL be WEIGHT when spike[i-1] is 1, else 0. spike[i-1] is the registered value, so each stage adds 1 cycle of latency.
REQ-005 With step=0, V_i and R_i SHALL hold and every spike bit SHALL be 0 on the next edge.
REQ-006 With step=1 and R_i!=0: R_i decrements by 1, V_i is 0, spike[i] is 0, and I_i is discarded.
REQ-007 With step=1 and R_i=0: S = V_i - (V_i >> LEAK_SHIFT) + I_i, computed at W+1 bits.
- If S > 2^W-1, S saturates to 2^W-1.
- If S >= thresh: spike[i]=1, V_i=0, R_i=REFRAC.
- Otherwise: spike[i]=0, V_i=S.
REQ-008 thresh=0 SHALL cause a spike on every step where R_i=0, including with I_i=0.
REQ-009 Each spike SHALL be a single-cycle pulse. Consecutive step=1 cycles with REFRAC=0 MAY produce back-to-back pulses.
REQ-010 spike_cnt SHALL increment by 1 on each edge where spike[N_NEURONS-1] is registered as 1, wrapping 65535 -> 0.
REQ-011 cnt_clr=1 SHALL clear spike_cnt to 0 on the edge. This takes priority over a simultaneous increment, so the result is 0.
REQ-012 mon_v SHALL be the combinational V_{mon_sel}. For mon_sel >= N_NEURONS, mon_v SHALL be 0.
REQ-013 All neurons SHALL update in parallel on the same edge. There is no other state machine.
REQ-014 Changing thresh or isyn between steps SHALL affect only the next step. There is no input buffering.

Reset
REQ-015 rst_n=0 SHALL asynchronously force all V_i=0, R_i=0, spike=0 and spike_cnt=0. mon_v then reads 0.
REQ-016 Reset asserted mid-refractory or mid-integration SHALL discard all state. The first step after release behaves as from power-up.
REQ-017 Reset release is synchronous to clk. The first edge with rst_n=1 MAY perform a step.

Verification
All scenarios use default parameters, thresh=200 unless stated, and step=1 every cycle unless stated.
REQ-018 Reset, then isyn=0 for 10 cycles -> all V=0, spike=0, spike_cnt=0.
REQ-019 isyn=100 from reset.
- V_0 goes 100, 175, then sums to 232, so spike[0]=1 on edge 3 with V_0=0.
- R_0 then holds V_0=0 for edges 4-5, and V_0=100 on edge 6.
- spike[1]=1 on edge 4 (0+255 >= 200), spike[2]=1 on edge 5, spike_cnt=1 after edge 5.
REQ-020 Saturation: thresh=255, isyn=200 -> V_0=200 after edge 1. Edge 2 sum 350 saturates to 255, so spike[0]=1.
REQ-021 Step gating: isyn=100, deassert step after edge 2 (V_0=175) for 5 cycles -> V_0 stays 175 and spike=0. Reasserting step gives a spike on the next edge.
REQ-022 cnt_clr and spike[2] increment on the same edge -> spike_cnt=0. Also preload 65535 by driving 65535 spikes, or by forcing in simulation, then one more spike -> spike_cnt=0.
REQ-023 Reset pulse during R_0=2 -> all state is 0 immediately. With isyn=100 after release, V_0=100 on the first step edge.
